// File: rtl/axis_pkg.sv
// ---------------------------------------------------------------------------
// axis_pkg
// Shared AXI4-Stream definitions for the 2-port stream mux/demux family.
//   axis_state_t : frame-tracking state (IDLE, ACTIVE, DROP)
//   axis_beat_t  : one stream beat in the default configuration
//                  (32-bit data, 4-bit keep, 8-bit id/dest, 1-bit user).
//                  Parameterized modules build a local equivalent sized from
//                  their own parameters.
// ---------------------------------------------------------------------------
package axis_pkg;

  localparam int AXIS_DATA_W = 32;
  localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;
  localparam int AXIS_ID_W   = 8;
  localparam int AXIS_DEST_W = 8;
  localparam int AXIS_USER_W = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // no frame open, next beat starts a frame
    ACTIVE = 2'd1,  // frame open, beats follow the latched port
    DROP   = 2'd2   // frame open, beats are consumed and discarded
  } axis_state_t;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] data;
    logic [AXIS_KEEP_W-1:0] keep;
    logic                   last;
    logic [AXIS_ID_W-1:0]   id;
    logic [AXIS_DEST_W-1:0] dest;
    logic [AXIS_USER_W-1:0] user;
  } axis_beat_t;

endpackage

// File: rtl/axis_skid_reg.sv
// ---------------------------------------------------------------------------
// axis_skid_reg
// Two-entry valid/ready register slice: an output register plus a temp
// (skid) register, with a registered s_ready. Sustains one beat per cycle
// and absorbs at most two beats while m_ready is held low.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   s_data/s_valid  input beat; s_valid must only be asserted while s_ready
//   s_ready         registered ready toward the source
//   m_data/m_valid  output beat, held stable until m_ready
//   m_ready         ready from the consumer of the output register
// ---------------------------------------------------------------------------
module axis_skid_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic             out_valid_q, out_valid_d;
  logic             temp_valid_q, temp_valid_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] out_q, temp_q;
  logic             in_to_out, in_to_temp, temp_to_out;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    out_valid_d  = out_valid_q;
    temp_valid_d = temp_valid_q;
    in_to_out    = 1'b0;
    in_to_temp   = 1'b0;
    temp_to_out  = 1'b0;

    // Ready next cycle unless the temp slot is (or is about to be) occupied
    // while the output register cannot drain.
    ready_d = m_ready || (!temp_valid_q && (!out_valid_q || !s_valid));

    if (ready_q) begin
      // Temp is empty whenever ready_q is high.
      if (m_ready || !out_valid_q) begin
        out_valid_d = s_valid;
        in_to_out   = s_valid;
      end else begin
        temp_valid_d = s_valid;
        in_to_temp   = s_valid;
      end
    end else if (m_ready || !out_valid_q) begin
      out_valid_d  = temp_valid_q;
      temp_valid_d = 1'b0;
      temp_to_out  = temp_valid_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q  <= 1'b0;
      temp_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      temp_valid_q <= temp_valid_d;
      ready_q      <= ready_d;
    end
  end

  // NOTE: payload registers are reset too because the outputs must read zero
  // during reset; loads are qualified by valid so an idle output keeps its
  // last beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q  <= '0;
      temp_q <= '0;
    end else begin
      if (in_to_out)        out_q <= s_data;
      else if (temp_to_out) out_q <= temp_q;
      if (in_to_temp)       temp_q <= s_data;
    end
  end

  assign s_ready = ready_q;
  assign m_valid = out_valid_q;
  assign m_data  = out_q;

endmodule

// File: rtl/axis_demux_2port.sv
// ---------------------------------------------------------------------------
// axis_demux_2port
// AXI4-Stream 1-to-2 frame demultiplexer. The destination port is sampled
// from `select` on the first beat of each frame and held until tlast. Beats
// pass through an axis_skid_reg (1-cycle latency, full throughput,
// registered ready) carrying the port bit alongside the payload.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   s_axis_*                 input stream (tready is an output)
//   m00_axis_*, m01_axis_*   output streams (tready are inputs)
//   enable                   permits a new frame to start
//   select                   destination port, sampled at frame start
//   drop                     (AXIS_DEMUX_DROP_EN only) discard the frame,
//                            sampled at frame start
// Build option: define AXIS_DEMUX_DROP_EN to add the drop port and DROP state.
// ---------------------------------------------------------------------------
module axis_demux_2port
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter bit ID_ENABLE   = 1'b0,
  parameter int ID_WIDTH    = 8,
  parameter bit DEST_ENABLE = 1'b0,
  parameter int DEST_WIDTH  = 8,
  parameter bit USER_ENABLE = 1'b1,
  parameter int USER_WIDTH  = 1
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,

  output logic [DATA_WIDTH-1:0] m00_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m00_axis_tkeep,
  output logic                  m00_axis_tvalid,
  input  logic                  m00_axis_tready,
  output logic                  m00_axis_tlast,
  output logic [ID_WIDTH-1:0]   m00_axis_tid,
  output logic [DEST_WIDTH-1:0] m00_axis_tdest,
  output logic [USER_WIDTH-1:0] m00_axis_tuser,

  output logic [DATA_WIDTH-1:0] m01_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m01_axis_tkeep,
  output logic                  m01_axis_tvalid,
  input  logic                  m01_axis_tready,
  output logic                  m01_axis_tlast,
  output logic [ID_WIDTH-1:0]   m01_axis_tid,
  output logic [DEST_WIDTH-1:0] m01_axis_tdest,
  output logic [USER_WIDTH-1:0] m01_axis_tuser,

  input  logic                  enable,
  input  logic                  select
`ifdef AXIS_DEMUX_DROP_EN
  ,
  input  logic                  drop
`endif
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic [ID_WIDTH-1:0]   id;
    logic [DEST_WIDTH-1:0] dest;
    logic [USER_WIDTH-1:0] user;
  } port_beat_t;

  typedef struct packed {
    logic       sel;   // destination port of this beat
    port_beat_t beat;
  } routed_beat_t;

  localparam int BEAT_W = $bits(routed_beat_t);

  axis_state_t  state_q, state_d;
  logic         sel_q;
  logic         beat_sel;       // port for the beat currently offered
  logic         frame_drop;     // beat currently offered is discarded
  logic         accept;
  logic         skid_ready;
  logic         skid_in_valid;
  routed_beat_t in_beat, out_beat;
  logic [BEAT_W-1:0] out_vec;
  logic         out_valid, out_ready;
  port_beat_t   hold0_q, hold1_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && accept) sel_q <= select;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        // Single-beat frames never leave IDLE, so select is re-sampled
        // on every beat.
        if (accept && !s_axis_tlast) begin
`ifdef AXIS_DEMUX_DROP_EN
          state_d = drop ? DROP : ACTIVE;
`else
          state_d = ACTIVE;
`endif
        end
      end
      ACTIVE: if (accept && s_axis_tlast) state_d = IDLE;
`ifdef AXIS_DEMUX_DROP_EN
      DROP:   if (accept && s_axis_tlast) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    s_axis_tready = 1'b0;
    beat_sel      = sel_q;
    frame_drop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        beat_sel = select;
`ifdef AXIS_DEMUX_DROP_EN
        // A dropped frame bypasses the output stage, so it ignores its ready.
        frame_drop    = drop;
        s_axis_tready = enable && (skid_ready || drop);
`else
        s_axis_tready = enable && skid_ready;
`endif
      end
      // enable only gates frame start; an open frame always continues.
      ACTIVE: s_axis_tready = skid_ready;
`ifdef AXIS_DEMUX_DROP_EN
      DROP: begin
        frame_drop    = 1'b1;
        s_axis_tready = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign accept        = s_axis_tvalid && s_axis_tready;
  assign skid_in_valid = accept && !frame_drop;

  always_comb begin
    in_beat           = '0;
    in_beat.sel       = beat_sel;
    in_beat.beat.data = s_axis_tdata;
    in_beat.beat.keep = s_axis_tkeep;
    in_beat.beat.last = s_axis_tlast;
    in_beat.beat.id   = s_axis_tid;
    in_beat.beat.dest = s_axis_tdest;
    in_beat.beat.user = s_axis_tuser;
  end

  axis_skid_reg #(
    .WIDTH (BEAT_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .s_data  (in_beat),
    .s_valid (skid_in_valid),
    .s_ready (skid_ready),
    .m_data  (out_vec),
    .m_valid (out_valid),
    .m_ready (out_ready)
  );

  assign out_beat  = out_vec;
  assign out_ready = out_beat.sel ? m01_axis_tready : m00_axis_tready;

  // Each port shows the shared output register while it is the routed port;
  // otherwise it shows the last beat it presented, captured here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold0_q <= '0;
      hold1_q <= '0;
    end else if (out_beat.sel) begin
      hold1_q <= out_beat.beat;
    end else begin
      hold0_q <= out_beat.beat;
    end
  end

  port_beat_t p0, p1;
  assign p0 = out_beat.sel ? hold0_q : out_beat.beat;
  assign p1 = out_beat.sel ? out_beat.beat : hold1_q;

  assign m00_axis_tvalid = out_valid && !out_beat.sel;
  assign m00_axis_tdata  = p0.data;
  assign m00_axis_tkeep  = KEEP_ENABLE ? p0.keep : '1;
  assign m00_axis_tlast  = p0.last;
  assign m00_axis_tid    = ID_ENABLE   ? p0.id   : '0;
  assign m00_axis_tdest  = DEST_ENABLE ? p0.dest : '0;
  assign m00_axis_tuser  = USER_ENABLE ? p0.user : '0;

  assign m01_axis_tvalid = out_valid && out_beat.sel;
  assign m01_axis_tdata  = p1.data;
  assign m01_axis_tkeep  = KEEP_ENABLE ? p1.keep : '1;
  assign m01_axis_tlast  = p1.last;
  assign m01_axis_tid    = ID_ENABLE   ? p1.id   : '0;
  assign m01_axis_tdest  = DEST_ENABLE ? p1.dest : '0;
  assign m01_axis_tuser  = USER_ENABLE ? p1.user : '0;

endmodule

// File: tb/tb_axis_demux_2port.sv
// ---------------------------------------------------------------------------
// tb_axis_demux_2port
// Self-checking bench for axis_demux_2port in its default configuration.
// An input-side frame model pushes expected beats into one queue per output
// port on every accepted input beat; output monitors pop and compare on every
// output handshake, and also check the valid/payload hold rule under stall.
// ---------------------------------------------------------------------------
module tb_axis_demux_2port;
  import axis_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [7:0]  s_axis_tid;
  logic [7:0]  s_axis_tdest;
  logic [0:0]  s_axis_tuser;

  logic [31:0] m00_axis_tdata,  m01_axis_tdata;
  logic [3:0]  m00_axis_tkeep,  m01_axis_tkeep;
  logic        m00_axis_tvalid, m01_axis_tvalid;
  logic        m00_axis_tready, m01_axis_tready;
  logic        m00_axis_tlast,  m01_axis_tlast;
  logic [7:0]  m00_axis_tid,    m01_axis_tid;
  logic [7:0]  m00_axis_tdest,  m01_axis_tdest;
  logic [0:0]  m00_axis_tuser,  m01_axis_tuser;

  logic enable;
  logic select;
  logic drop;

  axis_demux_2port dut (
    .clk             (clk),
    .rst             (rst),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tkeep    (s_axis_tkeep),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tid      (s_axis_tid),
    .s_axis_tdest    (s_axis_tdest),
    .s_axis_tuser    (s_axis_tuser),
    .m00_axis_tdata  (m00_axis_tdata),
    .m00_axis_tkeep  (m00_axis_tkeep),
    .m00_axis_tvalid (m00_axis_tvalid),
    .m00_axis_tready (m00_axis_tready),
    .m00_axis_tlast  (m00_axis_tlast),
    .m00_axis_tid    (m00_axis_tid),
    .m00_axis_tdest  (m00_axis_tdest),
    .m00_axis_tuser  (m00_axis_tuser),
    .m01_axis_tdata  (m01_axis_tdata),
    .m01_axis_tkeep  (m01_axis_tkeep),
    .m01_axis_tvalid (m01_axis_tvalid),
    .m01_axis_tready (m01_axis_tready),
    .m01_axis_tlast  (m01_axis_tlast),
    .m01_axis_tid    (m01_axis_tid),
    .m01_axis_tdest  (m01_axis_tdest),
    .m01_axis_tuser  (m01_axis_tuser),
    .enable          (enable),
`ifdef AXIS_DEMUX_DROP_EN
    .drop            (drop),
`endif
    .select          (select)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  axis_beat_t exp_q0[$];
  axis_beat_t exp_q1[$];
  int         acc_count = 0;
  int         cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- input-side frame model ----------------
  logic       mdl_in_frame = 1'b0;
  logic       mdl_sel = 1'b0;
  logic       mdl_drop = 1'b0;
  axis_beat_t mdl_beat;

  always @(negedge clk) begin
    if (!rst) begin
      mdl_in_frame = 1'b0;
    end else if (s_axis_tvalid && s_axis_tready) begin
      acc_count++;
      if (!mdl_in_frame) begin
        mdl_sel  = select;
        mdl_drop = drop;
      end
      mdl_beat      = '0;
      mdl_beat.data = s_axis_tdata;
      mdl_beat.keep = s_axis_tkeep;   // keep enabled
      mdl_beat.last = s_axis_tlast;
      mdl_beat.user = s_axis_tuser;   // user enabled; id/dest disabled -> 0
      if (!mdl_drop) begin
        if (mdl_sel) exp_q1.push_back(mdl_beat);
        else         exp_q0.push_back(mdl_beat);
      end
      mdl_in_frame = !s_axis_tlast;
    end
  end

  // ---------------- output monitors ----------------
  axis_beat_t got0, got1, prev0, prev1, e0, e1;
  logic       stall0 = 1'b0, stall1 = 1'b0;

  assign got0 = {m00_axis_tdata, m00_axis_tkeep, m00_axis_tlast,
                 m00_axis_tid, m00_axis_tdest, m00_axis_tuser};
  assign got1 = {m01_axis_tdata, m01_axis_tkeep, m01_axis_tlast,
                 m01_axis_tid, m01_axis_tdest, m01_axis_tuser};

  always @(negedge clk) begin
    if (!rst) begin
      stall0 = 1'b0;
      stall1 = 1'b0;
    end else begin
      if (m00_axis_tvalid && m01_axis_tvalid) check("both_valid", 1, 0);
      if (stall0) check("m00_stall_hold", {m00_axis_tvalid, got0}, {1'b1, prev0});
      if (stall1) check("m01_stall_hold", {m01_axis_tvalid, got1}, {1'b1, prev1});
      if (m00_axis_tvalid && m00_axis_tready) begin
        if (exp_q0.size() == 0) check("m00_unexpected_beat", got0, 0);
        else begin
          e0 = exp_q0.pop_front();
          check("m00_beat", got0, e0);
        end
      end
      if (m01_axis_tvalid && m01_axis_tready) begin
        if (exp_q1.size() == 0) check("m01_unexpected_beat", got1, 0);
        else begin
          e1 = exp_q1.pop_front();
          check("m01_beat", got1, e1);
        end
      end
      stall0 = m00_axis_tvalid && !m00_axis_tready;
      stall1 = m01_axis_tvalid && !m01_axis_tready;
      prev0  = got0;
      prev1  = got1;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Offers one beat from #1 after a posedge and returns #1 after the posedge
  // on which it was accepted.
  task automatic send(input logic [31:0] d, input logic last, input logic sel, input logic dr);
    int   n = 0;
    logic acc = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = d[3:0] ^ 4'h9;
    s_axis_tlast  = last;
    s_axis_tid    = 8'h5A;
    s_axis_tdest  = 8'hC3;
    s_axis_tuser  = d[4];
    select        = sel;
    drop          = dr;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = s_axis_tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("accept_timeout", 0, 1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    drop          = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_timeout", (n < 300), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  int   t0, a0, len;
  logic fsel, bp_done;

  initial begin
    rst = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 32'hDEAD_BEEF; s_axis_tkeep = 4'hF; s_axis_tlast = 1'b0;
    s_axis_tid = 8'h0; s_axis_tdest = 8'h0; s_axis_tuser = 1'b0;
    m00_axis_tready = 1'b1; m01_axis_tready = 1'b1;
    enable = 1'b1; select = 1'b0; drop = 1'b0; bp_done = 1'b0;

    // 1: reset holds everything quiet even with tvalid high.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_m00_tvalid", m00_axis_tvalid, 0);
    check("rst_m01_tvalid", m01_axis_tvalid, 0);
    check("rst_m00_tdata", m00_axis_tdata, 0);
    check("rst_m01_tkeep", m01_axis_tkeep, 0);
    s_axis_tvalid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("ready_after_rst", s_axis_tready, 1);

    // 2: frame latched to m01 even though select flips mid-frame.
    send(32'hA0, 1'b0, 1'b1, 1'b0);
    send(32'hA1, 1'b0, 1'b1, 1'b0);
    send(32'hA2, 1'b0, 1'b0, 1'b0);
    send(32'hA3, 1'b1, 1'b0, 1'b0);
    wait_drain();

    // 3: back-to-back single-beat frames, one beat per cycle.
    t0 = cyc;
    send(32'h11, 1'b1, 1'b0, 1'b0);
    send(32'h22, 1'b1, 1'b1, 1'b0);
    send(32'h33, 1'b1, 1'b0, 1'b0);
    check("b2b_cycles", cyc - t0, 3);
    wait_drain();
    check("idle_m00_tvalid", m00_axis_tvalid, 0);
    check("m00_data_held", m00_axis_tdata, 32'h33);
    check("m01_data_held", m01_axis_tdata, 32'h22);

    // 4: enable low in IDLE blocks a new frame.
    enable = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'h55; s_axis_tlast = 1'b1; select = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("disabled_tready", s_axis_tready, 0);
      check("disabled_m00_tvalid", m00_axis_tvalid, 0);
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    enable = 1'b1;
    // enable dropping mid-frame must not stall the open frame.
    send(32'hB0, 1'b0, 1'b0, 1'b0);
    enable = 1'b0;
    send(32'hB1, 1'b0, 1'b1, 1'b0);
    send(32'hB2, 1'b1, 1'b1, 1'b0);
    enable = 1'b1;
    wait_drain();

    // 5: stalled m00 absorbs exactly two beats, then releases in order.
    m00_axis_tready = 1'b0;
    a0 = acc_count;
    fork
      begin
        send(32'hC0, 1'b0, 1'b0, 1'b0);
        send(32'hC1, 1'b0, 1'b0, 1'b0);
        send(32'hC2, 1'b0, 1'b0, 1'b0);
        send(32'hC3, 1'b1, 1'b0, 1'b0);
      end
    join_none
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("full_accepted", acc_count - a0, 2);
    check("full_tready", s_axis_tready, 0);
    @(posedge clk);
    #1;
    m00_axis_tready = 1'b1;
    wait fork;
    wait_drain();

`ifdef AXIS_DEMUX_DROP_EN
    // 6: dropped frame is consumed at full rate, nothing reaches an output.
    m00_axis_tready = 1'b0; m01_axis_tready = 1'b0;
    t0 = cyc;
    send(32'hD0, 1'b0, 1'b0, 1'b1);
    send(32'hD1, 1'b0, 1'b0, 1'b0);
    send(32'hD2, 1'b1, 1'b1, 1'b0);
    check("drop_cycles", cyc - t0, 3);
    check("drop_m00_tvalid", m00_axis_tvalid, 0);
    m00_axis_tready = 1'b1; m01_axis_tready = 1'b1;
    send(32'hE0, 1'b1, 1'b0, 1'b0);
    wait_drain();
`endif

    // Random frames under random backpressure and enable toggling.
    fork
      begin
        for (int f = 0; f < 20; f++) begin
          len  = $urandom_range(1, 4);
          fsel = 1'($urandom_range(0, 1));
          enable = 1'b1;
          for (int i = 0; i < len; i++) begin
            send({16'h0, f[7:0], i[7:0]}, (i == len - 1), (i == 0) ? fsel : ~fsel, 1'b0);
            enable = 1'($urandom_range(0, 1));
          end
        end
        enable  = 1'b1;
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          @(posedge clk);
          #1;
          m00_axis_tready = 1'($urandom_range(0, 1));
          m01_axis_tready = 1'($urandom_range(0, 1));
        end
      end
    join
    m00_axis_tready = 1'b1; m01_axis_tready = 1'b1;
    wait_drain();
    check("end_q0_empty", exp_q0.size(), 0);
    check("end_q1_empty", exp_q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_demux_2port.md
Name: axis_demux_2port

Overview:
AXI4-Stream 1-to-2 demultiplexer, the counterpart of the team's 2-port stream mux. It routes whole frames from one slave stream to master port m00 or m01. The port is chosen by the select input, sampled only at frame start. A registered output stage with a skid buffer gives full throughput and registered tready. It sits downstream of a shared producer (DMA or parser) to split traffic between two consumers.

Parameters:
DATA_WIDTH, 32, tdata width in bits
KEEP_ENABLE, (DATA_WIDTH>8), propagate tkeep
KEEP_WIDTH, (DATA_WIDTH/8), tkeep width
ID_ENABLE, 0, propagate tid
ID_WIDTH, 8, tid width
DEST_ENABLE, 0, propagate tdest
DEST_WIDTH, 8, tdest width
USER_ENABLE, 1, propagate tuser
USER_WIDTH, 1, tuser width

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  asynchronous active-low reset (low = reset)
s_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  in (tready out)  per params  input stream
m00_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  out (tready in)  per params  output port 0
m01_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  out (tready in)  per params  output port 1
enable  in  1  permit start of a new frame
select  in  1  destination port, sampled at frame start

Behaviour:
- Reset (rst low, async assert, sync deassert): s_axis_tready=0; m0x_tvalid=0; all other outputs 0; state=IDLE; sel_reg=0; skid buffer empty.
- States: IDLE (no frame open) and ACTIVE (frame open, routed to sel_reg).
- IDLE: s_axis_tready is asserted only if enable=1 and the output stage can accept a beat. On the first accepted beat (tvalid&&tready), sel_reg<=select. The beat goes to port select in the same cycle. If tlast=0, go to ACTIVE; otherwise stay in IDLE.
- ACTIVE: enable and select are ignored. Each beat goes to sel_reg. An accepted beat with tlast=1 returns the block to IDLE.
- Single-beat frames back-to-back: select is re-sampled every beat. Sustained rate is 1 beat/cycle.
- Output stage: one output register plus one temp (skid) register.
  - s_axis_tready is registered: high next cycle if the temp register is empty and either the output register will be empty or the selected m_tready is high.
  - Latency is 1 cycle from input acceptance to m0x_tvalid.
  - Beats are never dropped, duplicated or reordered.
- Only the selected port's tvalid is ever high. The unselected port's tvalid=0 and its data outputs hold their last value.
- AXI rule: once m0x_tvalid=1, it and its payload hold until m0x_tready=1.
- Disabled sidebands: KEEP_ENABLE=0 gives tkeep all-ones. ID/DEST/USER disabled give 0.
- enable dropping mid-frame does not stall the open frame.
- Reset mid-frame: the frame is truncated and no tlast is emitted. Sinks must tolerate this.
- Full: with the selected m_tready=0, at most 2 beats are absorbed, then s_axis_tready=0.

Optional Feature:
AXIS_DEMUX_DROP_EN
- Defined: adds input port drop (1 bit), sampled with select at frame start. If drop=1, the frame is consumed at 1 beat/cycle with s_axis_tready=1 regardless of m_tready, and no m0x_tvalid is raised for any beat. The state machine gains a DROP state, exited on the tlast beat.
- Undefined: no drop port and no DROP state.

Decomposition:
- Shared package axis_pkg: state enum (IDLE, ACTIVE, DROP) and a frame-beat struct (data, keep, last, id, dest, user) sized from localparams.
- Sub-module axis_skid_reg: the 2-entry output/temp register with registered ready. It is reusable by the mux.

Test Plan:
1. Reset with rst=0 and tvalid=1 -> all tvalid=0, s_axis_tready=0; release rst -> tready=1 by cycle 2 with enable=1.
2. Frame of 4 beats 0xA0..0xA3, select=1 at beat 0, select toggled to 0 at beat 2 -> all 4 beats on m01 in order, tlast on 0xA3, m00_tvalid stays 0.
3. Back-to-back single-beat frames 0x11 (sel 0), 0x22 (sel 1), 0x33 (sel 0), both m_tready=1 -> m00 gets 0x11 then 0x33, m01 gets 0x22, one beat per cycle.
4. enable=0 in IDLE with tvalid=1 -> tready=0 and nothing forwarded. enable dropped mid-frame -> frame completes.
5. m00_tready=0 for 5 cycles during a frame -> exactly 2 beats buffered, tready falls. On release, beats emerge in order with no loss.
6. With AXIS_DEMUX_DROP_EN defined: 3-beat frame with drop=1 -> consumed in 3 cycles, no output tvalid. The next frame (drop=0, select=0) appears on m00.
